// File: rtl/fifo_pkg.sv
// Shared constants and width helpers for the flexible single-clock FIFO.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fifo_pkg;

    // Read-mode selection for sync_fifo_flex.FWFT
    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

    // Pointer width: enough bits to address entries 0..depth-1 (at least 1 bit).
    function automatic int ptr_w(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    // Count width: enough bits to hold occupancy 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_wrap_ctr.sv
// Modulo-MAX up-counter used as a FIFO read or write pointer.
// Latency: value updates on the clock edge following inc/clr.
// Backpressure: none; the caller only pulses inc for accepted accesses.
//
// Ports: clk, rst (async, active-high), clr (sync to 0, wins over inc),
//        inc (advance by one), value (current pointer, wraps MAX-1 -> 0).
module fifo_wrap_ctr
    import fifo_pkg::*;
#(
    parameter int MAX = 4,
    parameter int W   = ptr_w(MAX)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] value
);

    logic [W-1:0] value_q;
    logic [W-1:0] value_d;

    // Wrap by explicit compare so non-power-of-2 depths never index past MAX-1.
    always_comb begin
        value_d = value_q;
        if (clr) begin
            value_d = '0;
        end else if (inc) begin
            if (value_q == W'(MAX - 1)) begin
                value_d = '0;
            end else begin
                value_d = value_q + W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO, any depth >= 2, with count, almost flags, STD/FWFT read and sticky errors.
// Latency: write -> readable 1 cycle; STD read data 1 cycle after rden, FWFT head is combinational.
// Backpressure: writes refused when full (unless a read is accepted same cycle), reads refused when empty.
//
// Ports: clk, rst (async, active-high), clr (sync flush), wren/wd (write),
//        rden (read / FWFT pop), rd/rd_valid (read data), full, empty,
//        almost_full, almost_empty, count (0..DEPTH), overflow/underflow (sticky).
module sync_fifo_flex
    import fifo_pkg::*;
#(
    parameter int DWIDTH    = 8,
    parameter int DEPTH     = 4,
    parameter int FWFT      = FIFO_STD,
    parameter int AF_THRESH = DEPTH - 1,
    parameter int AE_THRESH = 1,
    localparam int CW       = cnt_w(DEPTH),
    localparam int PW       = ptr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              wren,
    input  logic [DWIDTH-1:0] wd,
    input  logic              rden,
    output logic [DWIDTH-1:0] rd,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [CW-1:0]     count,
    output logic              overflow,
    output logic              underflow
);

    logic [DWIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              wr_acc;
    logic              rd_acc;
    logic [DWIDTH-1:0] head_dat;

    // Flags come straight from the registered count, so they carry no extra latency.
    assign full         = (count_q == CW'(DEPTH));
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= CW'(AF_THRESH));
    assign almost_empty = (count_q <= CW'(AE_THRESH));
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // Flush wins over any request in the same cycle. A read accepted alongside
    // a write frees the slot, so a full FIFO can still take the write.
    assign rd_acc = !clr && rden && !empty;
    assign wr_acc = !clr && wren && (!full || rd_acc);

    fifo_wrap_ctr #(.MAX(DEPTH), .W(PW)) u_wr_ptr (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .inc   (wr_acc),
        .value (wr_ptr)
    );

    fifo_wrap_ctr #(.MAX(DEPTH), .W(PW)) u_rd_ptr (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .inc   (rd_acc),
        .value (rd_ptr)
    );

    always_comb begin
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (clr) begin
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            unique case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            if (wren && !wr_acc) overflow_d  = 1'b1;
            if (rden && !rd_acc) underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately not reset; the count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr] <= wd;
        end
    end

    assign head_dat = mem_q[rd_ptr];

    if (FWFT == FIFO_FWFT) begin : g_fwft
        // Head is presented directly; masked to zero while empty so stale or
        // never-written storage does not leak onto rd.
        assign rd       = empty ? '0 : head_dat;
        assign rd_valid = !empty;
    end else begin : g_std
        logic [DWIDTH-1:0] rd_q, rd_d;
        logic              rd_valid_q, rd_valid_d;

        // rd holds its last value between reads; rd_valid is a single-cycle strobe.
        always_comb begin
            rd_d       = rd_q;
            rd_valid_d = 1'b0;
            if (rd_acc) begin
                rd_d       = head_dat;
                rd_valid_d = 1'b1;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rd_q       <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                rd_q       <= rd_d;
                rd_valid_q <= rd_valid_d;
            end
        end

        assign rd       = rd_q;
        assign rd_valid = rd_valid_q;
    end

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Testbench for sync_fifo_flex: a DEPTH=4 standard-mode instance and a DEPTH=5 FWFT instance.
// Latency: inputs driven 1 time unit after a rising edge, outputs sampled at the same point.
// Backpressure: the reference queues decide acceptance from their own occupancy.
module tb_sync_fifo_flex;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // Standard-mode instance, DEPTH=4, AF=3, AE=1
    logic       s_clr, s_wren, s_rden;
    logic [7:0] s_wd, s_rd;
    logic       s_rv, s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
    logic [2:0] s_count;

    // FWFT instance, DEPTH=5, AF=4, AE=1
    logic       f_clr, f_wren, f_rden;
    logic [7:0] f_wd, f_rd;
    logic       f_rv, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
    logic [2:0] f_count;

    sync_fifo_flex #(.DWIDTH(8), .DEPTH(4), .FWFT(0), .AF_THRESH(3), .AE_THRESH(1)) u_std (
        .clk(clk), .rst(rst), .clr(s_clr), .wren(s_wren), .wd(s_wd), .rden(s_rden),
        .rd(s_rd), .rd_valid(s_rv), .full(s_full), .empty(s_empty),
        .almost_full(s_af), .almost_empty(s_ae), .count(s_count),
        .overflow(s_ovf), .underflow(s_unf)
    );

    sync_fifo_flex #(.DWIDTH(8), .DEPTH(5), .FWFT(1), .AF_THRESH(4), .AE_THRESH(1)) u_fwft (
        .clk(clk), .rst(rst), .clr(f_clr), .wren(f_wren), .wd(f_wd), .rden(f_rden),
        .rd(f_rd), .rd_valid(f_rv), .full(f_full), .empty(f_empty),
        .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
        .overflow(f_ovf), .underflow(f_unf)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state
    logic [7:0] sm[$];   // std contents
    logic [7:0] se[$];   // std expected read outputs awaiting rd_valid
    logic [7:0] s_last;
    bit         s_movf, s_munf, s_mrv;
    logic [7:0] fm[$];   // fwft contents
    bit         f_movf, f_munf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic std_chk();
        chk("std_count", 32'(s_count), 32'(sm.size()));
        chk("std_full",  32'(s_full),  32'(sm.size() == 4));
        chk("std_empty", 32'(s_empty), 32'(sm.size() == 0));
        chk("std_af",    32'(s_af),    32'(sm.size() >= 3));
        chk("std_ae",    32'(s_ae),    32'(sm.size() <= 1));
        chk("std_ovf",   32'(s_ovf),   32'(s_movf));
        chk("std_unf",   32'(s_unf),   32'(s_munf));
        chk("std_rv",    32'(s_rv),    32'(s_mrv));
        if (s_rv) begin
            if (se.size() == 0) chk("std_rv_unexpected", 32'(s_rv), 32'd0);
            else                chk("std_rd", 32'(s_rd), 32'(se.pop_front()));
        end else begin
            chk("std_rd_hold", 32'(s_rd), 32'(s_last));
        end
    endtask

    task automatic std_op(input bit clr, input bit wr, input bit rd, input logic [7:0] dat);
        bit rd_ok, wr_ok;
        s_clr = clr; s_wren = wr; s_rden = rd; s_wd = dat;
        if (clr) begin
            sm.delete();
            s_movf = 0; s_munf = 0; s_mrv = 0;
        end else begin
            rd_ok = rd && (sm.size() > 0);
            wr_ok = wr && ((sm.size() < 4) || rd_ok);
            if (rd && !rd_ok) s_munf = 1;
            if (wr && !wr_ok) s_movf = 1;
            s_mrv = rd_ok;
            if (rd_ok) begin
                s_last = sm.pop_front();
                se.push_back(s_last);
            end
            if (wr_ok) sm.push_back(dat);
        end
        @(posedge clk); #1;
        s_clr = 0; s_wren = 0; s_rden = 0;
        std_chk();
    endtask

    task automatic fw_chk();
        chk("fw_count", 32'(f_count), 32'(fm.size()));
        chk("fw_full",  32'(f_full),  32'(fm.size() == 5));
        chk("fw_empty", 32'(f_empty), 32'(fm.size() == 0));
        chk("fw_af",    32'(f_af),    32'(fm.size() >= 4));
        chk("fw_ae",    32'(f_ae),    32'(fm.size() <= 1));
        chk("fw_ovf",   32'(f_ovf),   32'(f_movf));
        chk("fw_unf",   32'(f_unf),   32'(f_munf));
        chk("fw_rv",    32'(f_rv),    32'(fm.size() > 0));
        if (fm.size() > 0) chk("fw_head", 32'(f_rd), 32'(fm[0]));
        else               chk("fw_rd_zero", 32'(f_rd), 32'd0);
    endtask

    task automatic fw_op(input bit wr, input bit rd, input logic [7:0] dat);
        bit rd_ok, wr_ok;
        f_wren = wr; f_rden = rd; f_wd = dat;
        #1;
        rd_ok = rd && (fm.size() > 0);
        wr_ok = wr && ((fm.size() < 5) || rd_ok);
        if (rd && !rd_ok) f_munf = 1;
        if (wr && !wr_ok) f_movf = 1;
        if (rd_ok) chk("fw_pop", 32'(f_rd), 32'(fm.pop_front()));
        if (wr_ok) fm.push_back(dat);
        @(posedge clk); #1;
        f_wren = 0; f_rden = 0;
        fw_chk();
    endtask

    task automatic model_reset();
        sm.delete(); se.delete();
        s_last = '0; s_movf = 0; s_munf = 0; s_mrv = 0;
        fm.delete(); f_movf = 0; f_munf = 0;
    endtask

    initial begin
        rst = 1'b1;
        s_clr = 0; s_wren = 0; s_rden = 0; s_wd = '0;
        f_clr = 0; f_wren = 0; f_rden = 0; f_wd = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        std_chk();
        fw_chk();
        rst = 1'b0;
        @(posedge clk); #1;

        // ---- Standard mode, DEPTH=4 ----
        for (int i = 0; i < 4; i++) std_op(0, 1, 0, 8'(8'hA1 + i));
        std_op(0, 1, 0, 8'hA5);                   // write while full -> overflow
        for (int i = 0; i < 4; i++) std_op(0, 0, 1, 8'h00);
        std_op(0, 0, 1, 8'h00);                   // read while empty -> underflow, rd holds A4

        for (int i = 0; i < 3; i++) std_op(0, 1, 0, 8'(8'hC0 + i));
        std_op(1, 1, 0, 8'hEE);                   // flush beats write, errors cleared

        for (int i = 0; i < 4; i++) std_op(0, 1, 0, 8'(8'hB0 + i));
        std_op(0, 1, 1, 8'h55);                   // full + simultaneous read/write
        for (int i = 0; i < 4; i++) std_op(0, 0, 1, 8'h00);
        std_op(0, 1, 1, 8'h66);                   // empty + simultaneous
        std_op(0, 0, 1, 8'h00);

        // ---- FWFT mode, DEPTH=5 ----
        for (int i = 0; i < 5; i++) fw_op(1, 0, 8'(8'h10 + i));
        fw_op(1, 0, 8'h77);                       // overflow
        for (int i = 0; i < 5; i++) fw_op(0, 1, 8'h00);
        for (int i = 0; i < 3; i++) fw_op(1, 0, 8'(8'h20 + i));
        for (int i = 0; i < 2; i++) fw_op(0, 1, 8'h00);
        for (int i = 0; i < 4; i++) fw_op(1, 0, 8'(8'h23 + i));  // pointers wrap
        fw_op(1, 1, 8'h55);                       // full + simultaneous
        for (int i = 0; i < 5; i++) fw_op(0, 1, 8'h00);
        fw_op(0, 1, 8'h00);                       // underflow

        // ---- Asynchronous reset in the middle of a burst ----
        std_op(0, 1, 0, 8'hD0);
        std_op(0, 1, 0, 8'hD1);
        fw_op(1, 0, 8'hE0);
        s_wren = 1; s_wd = 8'hD2;
        f_wren = 1; f_wd = 8'hE1;
        rst = 1'b1;
        #2;
        s_wren = 0; f_wren = 0;
        model_reset();
        std_chk();
        fw_chk();
        @(posedge clk); #1;
        rst = 1'b0;
        std_op(0, 1, 0, 8'hF0);
        std_op(0, 0, 1, 8'h00);
        std_op(0, 0, 0, 8'h00);
        fw_op(1, 0, 8'hF1);
        fw_op(0, 1, 8'h00);

        chk("std_sb_drained", 32'(se.size()), 32'd0);
        chk("fw_sb_drained",  32'(fm.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
